// File: rtl/tick_sequencer.sv
// tick_sequencer: steps a programmable tick once every enabled source has reported done.
// Optional watchdog: define TICK_SEQUENCER_TIMEOUT_EN to force a step after TIMEOUT_CYC stalled WAIT cycles.
// Ports:
//   CLK, RST     clock, asynchronous active-high reset
//   start_i      pulse, latch cfg_* and begin sequencing (IDLE/FINISHED only)
//   stop_i       pulse, abort to IDLE (beats start_i and completion)
//   cfg_init_i   first tick value        cfg_last_i  terminal tick value
//   cfg_dir_i    1 = up, 0 = down        cfg_wrap_i  1 = reload init at terminal
//   cfg_mask_i   participating sources   done_i      per-source done
//   tick_o       current tick            next_tick_o one-cycle pulse per step
//   busy_o       waiting for sources     finished_o  terminal reached without wrap
//   pending_o    sticky done flags       step_cnt_o  saturating step count
//   timeout_o    sticky watchdog flag (0 when the watchdog is not built)
module tick_sequencer #(
   parameter int INPUT_RESO  = 8,
   parameter int N_SRC       = 2,
   parameter int CNT_W       = 16,
   parameter int RESET_TICK  = 1,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start_i,
   input  logic                  stop_i,
   input  logic [INPUT_RESO-1:0] cfg_init_i,
   input  logic [INPUT_RESO-1:0] cfg_last_i,
   input  logic                  cfg_dir_i,
   input  logic                  cfg_wrap_i,
   input  logic [N_SRC-1:0]      cfg_mask_i,
   input  logic [N_SRC-1:0]      done_i,
   output logic [INPUT_RESO-1:0] tick_o,
   output logic                  next_tick_o,
   output logic                  busy_o,
   output logic                  finished_o,
   output logic [N_SRC-1:0]      pending_o,
   output logic [CNT_W-1:0]      step_cnt_o,
   output logic                  timeout_o
);
   typedef enum logic [1:0] {IDLE, WAIT, FINISHED} state_t;
   state_t state, state_n;
   logic [INPUT_RESO-1:0] init_q, last_q, tick_n;
   logic dir_q, wrap_q, fin_n, pulse_n, done_all, fire, load;
   logic [N_SRC-1:0] mask_q, pend_n, acc;
   logic [CNT_W-1:0] step_n;
   // A done arriving in the completing cycle counts toward completion.
   assign acc      = pending_o | (done_i & mask_q);
   assign done_all = acc == mask_q;
   assign load     = state != WAIT && start_i && !stop_i;
`ifdef TICK_SEQUENCER_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_q;
   assign fire = state == WAIT && wd_q == WD_W'(TIMEOUT_CYC - 1);
   // Watchdog counts only uninterrupted stalled WAIT cycles.
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         wd_q      <= '0;
         timeout_o <= 1'b0;
      end else begin
         wd_q      <= (state == WAIT && state_n == WAIT && !pulse_n) ? wd_q + WD_W'(1) : '0;
         timeout_o <= load ? 1'b0 : timeout_o | (fire && !done_all && !stop_i);
      end
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYC;
   assign fire      = 1'b0;
   assign timeout_o = 1'b0;
`endif
   always_comb begin
      state_n = state;
      tick_n  = tick_o;
      pend_n  = pending_o;
      step_n  = step_cnt_o;
      fin_n   = finished_o;
      pulse_n = 1'b0;
      case (state)
         WAIT:
            if (stop_i) begin
               state_n = IDLE;
               pend_n  = '0;
            end else if (done_all || fire) begin
               pulse_n = 1'b1;
               pend_n  = '0;
               step_n  = &step_cnt_o ? step_cnt_o : step_cnt_o + CNT_W'(1);
               tick_n  = tick_o != last_q ? (dir_q ? tick_o + INPUT_RESO'(1) : tick_o - INPUT_RESO'(1))
                       : wrap_q ? init_q : tick_o;
               if (tick_o == last_q && !wrap_q) begin
                  fin_n   = 1'b1;
                  state_n = FINISHED;
               end
            end else pend_n = acc;
         default:
            if (stop_i) begin
               state_n = IDLE;
               fin_n   = 1'b0;
            end else if (start_i) begin
               state_n = WAIT;
               tick_n  = cfg_init_i;
               pend_n  = '0;
               step_n  = '0;
               fin_n   = 1'b0;
            end
      endcase
   end
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state       <= IDLE;
         tick_o      <= INPUT_RESO'(RESET_TICK);
         next_tick_o <= 1'b0;
         busy_o      <= 1'b0;
         finished_o  <= 1'b0;
         pending_o   <= '0;
         step_cnt_o  <= '0;
         init_q      <= '0;
         last_q      <= '0;
         dir_q       <= 1'b0;
         wrap_q      <= 1'b0;
         mask_q      <= '0;
      end else begin
         state       <= state_n;
         tick_o      <= tick_n;
         next_tick_o <= pulse_n;
         busy_o      <= state_n == WAIT;
         finished_o  <= fin_n;
         pending_o   <= pend_n;
         step_cnt_o  <= step_n;
         if (load) begin
            init_q <= cfg_init_i;
            last_q <= cfg_last_i;
            dir_q  <= cfg_dir_i;
            wrap_q <= cfg_wrap_i;
            mask_q <= cfg_mask_i;
         end
      end
endmodule

// File: tb/tb_tick_sequencer.sv
// tb_tick_sequencer: directed and randomized checks of tick_sequencer against a behavioural model.
module tb_tick_sequencer;
   logic CLK = 1'b0, RST = 1'b1;
   logic start_i = 0, stop_i = 0, cfg_dir_i = 0, cfg_wrap_i = 0;
   logic [7:0] cfg_init_i = 0, cfg_last_i = 0, tick_o;
   logic [1:0] cfg_mask_i = 0, done_i = 0, pending_o;
   logic next_tick_o, busy_o, finished_o, timeout_o;
   logic [15:0] step_cnt_o;
   always #5 CLK = ~CLK;
   tick_sequencer #(.TIMEOUT_CYC(8)) dut (
      .CLK(CLK), .RST(RST), .start_i(start_i), .stop_i(stop_i),
      .cfg_init_i(cfg_init_i), .cfg_last_i(cfg_last_i), .cfg_dir_i(cfg_dir_i),
      .cfg_wrap_i(cfg_wrap_i), .cfg_mask_i(cfg_mask_i), .done_i(done_i),
      .tick_o(tick_o), .next_tick_o(next_tick_o), .busy_o(busy_o),
      .finished_o(finished_o), .pending_o(pending_o), .step_cnt_o(step_cnt_o),
      .timeout_o(timeout_o));
   int checks = 0, errors = 0;
   // Behavioural model: mode 0 idle, 1 waiting for sources, 2 finished.
   int mode, m_tick, m_step, m_wd, c_init, c_last;
   bit m_pulse, m_fin, m_to, c_dir, c_wrap;
   bit [1:0] m_pend, c_mask;
   logic [29:0] act_v, exp_v;
   assign act_v = {tick_o, next_tick_o, busy_o, finished_o, pending_o, step_cnt_o, timeout_o};
   task automatic model_reset();
      mode = 0; m_tick = 1; m_step = 0; m_wd = 0;
      m_pulse = 0; m_fin = 0; m_to = 0; m_pend = 0;
   endtask
   task automatic cyc();
      bit [1:0] hit;
      bit nat, forced;
      @(posedge CLK);
      m_pulse = 0;
      if (mode == 1) begin
         if (stop_i) begin
            mode = 0; m_pend = 0; m_wd = 0;
         end else begin
            hit = done_i & c_mask;
            nat = (m_pend | hit) == c_mask;
            forced = 0;
`ifdef TICK_SEQUENCER_TIMEOUT_EN
            forced = !nat && m_wd == 7;
`endif
            if (nat || forced) begin
               m_pulse = 1; m_pend = 0; m_wd = 0;
               if (forced) m_to = 1;
               if (m_step < 65535) m_step++;
               if (m_tick != c_last) m_tick = c_dir ? (m_tick + 1) % 256 : (m_tick + 255) % 256;
               else if (c_wrap) m_tick = c_init;
               else begin m_fin = 1; mode = 2; end
            end else begin
               m_pend |= hit; m_wd++;
            end
         end
      end else if (stop_i) begin
         mode = 0; m_fin = 0;
      end else if (start_i) begin
         c_init = cfg_init_i; c_last = cfg_last_i; c_dir = cfg_dir_i; c_wrap = cfg_wrap_i; c_mask = cfg_mask_i;
         m_tick = c_init; m_pend = 0; m_step = 0; m_fin = 0; m_to = 0; m_wd = 0; mode = 1;
      end
      #1;
      exp_v = {8'(m_tick), m_pulse, mode == 1, m_fin, m_pend, 16'(m_step), m_to};
   endtask
   task automatic drv(input bit st, input bit sp, input bit [1:0] d);
      start_i = st; stop_i = sp; done_i = d;
      cyc();
   endtask
   task automatic cfgset(input int init, input int last, input bit dir, input bit wrap, input bit [1:0] mask);
      cfg_init_i = 8'(init); cfg_last_i = 8'(last); cfg_dir_i = dir; cfg_wrap_i = wrap; cfg_mask_i = mask;
   endtask
   task automatic test_reset();
      RST = 1; model_reset();
      repeat (3) @(posedge CLK);
      #1 RST = 0;
      checks++; if (act_v !== {8'd1, 22'd0}) begin errors++; $display("FAIL reset_state got %h exp %h", act_v, {8'd1, 22'd0}); end
      drv(0, 0, 2'b11);
      checks++; if (act_v !== {8'd1, 22'd0}) begin errors++; $display("FAIL idle_state got %h exp %h", act_v, {8'd1, 22'd0}); end
   endtask
   task automatic test_down_no_wrap();
      cfgset(5, 3, 0, 0, 2'b11);
      drv(1, 0, 0);
      checks++; if (tick_o !== 8'd5 || busy_o !== 1'b1 || step_cnt_o !== 16'd0) begin errors++; $display("FAIL down_start tick %0d busy %0d exp 5 1", tick_o, busy_o); end
      drv(0, 0, 2'b01);
      drv(0, 0, 2'b00);
      drv(0, 0, 2'b00);
      checks++; if (pending_o !== 2'b01 || next_tick_o !== 1'b0) begin errors++; $display("FAIL down_pending got %b exp 01", pending_o); end
      drv(0, 0, 2'b10);
      checks++; if (next_tick_o !== 1'b1 || tick_o !== 8'd4 || pending_o !== 2'b00) begin errors++; $display("FAIL down_step1 pulse %0d tick %0d exp 1 4", next_tick_o, tick_o); end
      drv(0, 0, 2'b00);
      checks++; if (next_tick_o !== 1'b0) begin errors++; $display("FAIL down_pulse_width got %0d exp 0", next_tick_o); end
      drv(0, 0, 2'b01);
      drv(0, 0, 2'b01);
      drv(0, 0, 2'b10);
      checks++; if (next_tick_o !== 1'b1 || tick_o !== 8'd3) begin errors++; $display("FAIL down_step2 pulse %0d tick %0d exp 1 3", next_tick_o, tick_o); end
      drv(0, 0, 2'b11);
      checks++; if (act_v !== {8'd3, 1'b1, 1'b0, 1'b1, 2'b00, 16'd3, 1'b0}) begin errors++; $display("FAIL down_terminal got %h exp %h", act_v, {8'd3, 1'b1, 1'b0, 1'b1, 2'b00, 16'd3, 1'b0}); end
      drv(0, 0, 2'b11);
      checks++; if (act_v !== {8'd3, 1'b0, 1'b0, 1'b1, 2'b00, 16'd3, 1'b0}) begin errors++; $display("FAIL down_finished_hold got %h exp %h", act_v, {8'd3, 1'b0, 1'b0, 1'b1, 2'b00, 16'd3, 1'b0}); end
   endtask
   task automatic test_up_wrap();
      int seq [4] = '{255, 0, 1, 254};
      cfgset(254, 1, 1, 1, 2'b01);
      drv(1, 0, 0);
      checks++; if (tick_o !== 8'd254 || finished_o !== 1'b0) begin errors++; $display("FAIL wrap_start tick %0d fin %0d exp 254 0", tick_o, finished_o); end
      for (int i = 0; i < 4; i++) begin
         drv(0, 0, {1'($urandom), 1'b1});
         checks++; if (tick_o !== 8'(seq[i]) || next_tick_o !== 1'b1 || pending_o !== 2'b00) begin errors++; $display("FAIL wrap_seq%0d tick %0d pulse %0d pend %b exp %0d 1 00", i, tick_o, next_tick_o, pending_o, seq[i]); end
      end
      drv(0, 0, 2'b10);
      checks++; if (next_tick_o !== 1'b0 || pending_o !== 2'b00 || tick_o !== 8'd254) begin errors++; $display("FAIL wrap_masked pulse %0d pend %b exp 0 00", next_tick_o, pending_o); end
   endtask
   task automatic test_reset_mid();
      @(posedge CLK); #3 RST = 1; model_reset();
      #1;
      checks++; if (act_v !== {8'd1, 22'd0}) begin errors++; $display("FAIL async_reset got %h exp %h", act_v, {8'd1, 22'd0}); end
      @(posedge CLK); #1 RST = 0;
   endtask
   task automatic test_stop_completion();
      cfgset(10, 0, 0, 0, 2'b11);
      drv(1, 0, 0);
      drv(0, 0, 2'b01);
      drv(0, 1, 2'b11);
      checks++; if (act_v !== {8'd10, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0, 1'b0}) begin errors++; $display("FAIL stop_vs_done got %h exp %h", act_v, {8'd10, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0, 1'b0}); end
      drv(1, 1, 0);
      checks++; if (busy_o !== 1'b0 || tick_o !== 8'd10) begin errors++; $display("FAIL stop_vs_start busy %0d tick %0d exp 0 10", busy_o, tick_o); end
   endtask
   task automatic test_same_cycle();
      cfgset(100, 0, 0, 1, 2'b11);
      drv(1, 0, 0);
      drv(0, 0, 2'b11);
      checks++; if (next_tick_o !== 1'b1 || tick_o !== 8'd99) begin errors++; $display("FAIL same_cycle pulse %0d tick %0d exp 1 99", next_tick_o, tick_o); end
      for (int i = 0; i < 3; i++) begin
         drv(0, 0, 2'b11);
         checks++; if (next_tick_o !== 1'b1 || tick_o !== 8'(98 - i)) begin errors++; $display("FAIL held_done%0d pulse %0d tick %0d exp 1 %0d", i, next_tick_o, tick_o, 98 - i); end
      end
      cfgset(7, 9, 1, 0, 2'b00);
      drv(1, 0, 0);
      checks++; if (tick_o !== 8'd96 || busy_o !== 1'b1 || next_tick_o !== 1'b0) begin errors++; $display("FAIL start_in_wait tick %0d exp 96", tick_o); end
      drv(0, 1, 0);
      drv(1, 0, 0);
      drv(0, 0, 0);
      drv(0, 0, 0);
      checks++; if (next_tick_o !== 1'b1 || tick_o !== 8'd9 || step_cnt_o !== 16'd2) begin errors++; $display("FAIL free_run tick %0d step %0d exp 9 2", tick_o, step_cnt_o); end
      drv(0, 0, 0);
      checks++; if (finished_o !== 1'b1 || tick_o !== 8'd9 || next_tick_o !== 1'b1) begin errors++; $display("FAIL free_run_end fin %0d tick %0d exp 1 9", finished_o, tick_o); end
      cfgset(0, 250, 0, 1, 2'b00);
      drv(1, 0, 0);
      checks++; if (finished_o !== 1'b0 || busy_o !== 1'b1 || tick_o !== 8'd0 || step_cnt_o !== 16'd0) begin errors++; $display("FAIL restart_finished fin %0d busy %0d tick %0d", finished_o, busy_o, tick_o); end
      drv(0, 0, 0);
      checks++; if (tick_o !== 8'd255) begin errors++; $display("FAIL underflow tick %0d exp 255", tick_o); end
      cfgset(4, 4, 1, 0, 2'b00);
      drv(0, 1, 0);
      drv(1, 0, 0);
      drv(0, 0, 0);
      drv(0, 1, 0);
      checks++; if (finished_o !== 1'b0 || busy_o !== 1'b0 || tick_o !== 8'd4) begin errors++; $display("FAIL stop_finished fin %0d busy %0d exp 0 0", finished_o, busy_o); end
   endtask
   task automatic test_random();
      int init;
      bit dir;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            init = $urandom_range(0, 255);
            dir = 1'($urandom);
            cfgset(init, (init + (dir ? 1 : 255) * $urandom_range(0, 5)) % 256, dir, 1'($urandom), 2'($urandom));
         end
         drv($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0, 2'($urandom_range(0, 3) == 0 ? 3 : $urandom));
         checks++; if (act_v !== exp_v) begin errors++; $display("FAIL random_cyc%0d got %h exp %h", i, act_v, exp_v); end
      end
   endtask
`ifdef TICK_SEQUENCER_TIMEOUT_EN
   task automatic test_timeout();
      drv(0, 1, 0);
      cfgset(5, 0, 0, 0, 2'b11);
      drv(1, 0, 0);
      for (int i = 0; i < 7; i++) drv(0, 0, 0);
      checks++; if (next_tick_o !== 1'b0 || timeout_o !== 1'b0) begin errors++; $display("FAIL wd_early pulse %0d to %0d exp 0 0", next_tick_o, timeout_o); end
      drv(0, 0, 0);
      checks++; if (next_tick_o !== 1'b1 || timeout_o !== 1'b1 || tick_o !== 8'd4) begin errors++; $display("FAIL wd_fire pulse %0d to %0d tick %0d exp 1 1 4", next_tick_o, timeout_o, tick_o); end
      drv(0, 0, 2'b11);
      checks++; if (timeout_o !== 1'b1 || tick_o !== 8'd3) begin errors++; $display("FAIL wd_sticky to %0d tick %0d exp 1 3", timeout_o, tick_o); end
      drv(0, 1, 0);
      drv(1, 0, 0);
      checks++; if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL wd_clear to %0d exp 0", timeout_o); end
   endtask
`endif
   initial begin
      test_reset();
      test_down_no_wrap();
      test_up_wrap();
      test_reset_mid();
      test_stop_completion();
      test_same_cycle();
`ifdef TICK_SEQUENCER_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
